// File: rtl/vector_pkg.sv
// Shared control-unit types for the vector-game datapath controllers.
package vector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FLYING    = 2'd1,
    ST_EXPLODING = 2'd2,
    ST_ARRIVED   = 2'd3
  } enemy_state_t;

  localparam int CNT_W = 4;

  // Terminal value of a modulo-n counter, in counter width.
  function automatic logic [CNT_W-1:0] cnt_last(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Modulo-N counter advanced by i_tick; i_clr wins over i_tick. o_tc flags the last count.
// Registered count, o_tc is a decode of it; no flow control.
module tick_counter
  import vector_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] LP_LAST = cnt_last(N);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (r_cnt == LP_LAST) r_cnt <= '0;
      else                  r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == LP_LAST);

endmodule

// File: rtl/enemy_control.sv
// Per-enemy flight controller: spawn, step toward X_BASE on divided frame ticks, explode on hit.
// All outputs registered (one-edge latency); no backpressure, events are pulses.
module enemy_control
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH              = 8,
  parameter int X_SPAWN                = 255,
  parameter int X_BASE                 = 0,
  parameter int STEP_DIV               = 4,
  parameter int DESTROY_ANIMATION_TIME = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 spawn_req,
  input  logic [OUT_WIDTH-1:0] spawn_y,
  input  logic                 hit,
  output logic [OUT_WIDTH-1:0] xenemy,
  output logic [OUT_WIDTH-1:0] yenemy,
  output logic                 enemy_active,
  output logic                 enemy_exploding,
  output logic                 enemy_killed,
  output logic                 reached_base
);

  localparam logic [OUT_WIDTH-1:0] LP_X_SPAWN = OUT_WIDTH'(X_SPAWN);
  localparam logic [OUT_WIDTH-1:0] LP_X_BASE  = OUT_WIDTH'(X_BASE);

  enemy_state_t r_state, w_nxt_state;

  logic [OUT_WIDTH-1:0] r_x, r_y, w_nxt_x, w_nxt_y, w_x_dec;
  logic r_active, r_exploding, r_killed, r_reached;
  logic w_nxt_killed, w_nxt_reached;
  logic w_step_clr, w_step_tick, w_step_tc;
  logic w_anim_clr, w_anim_tick, w_anim_tc;

  tick_counter #(.N(STEP_DIV)) u_step_div (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_step_clr),
    .i_tick (w_step_tick),
    .o_tc   (w_step_tc)
  );

  tick_counter #(.N(DESTROY_ANIMATION_TIME)) u_anim_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_anim_clr),
    .i_tick (w_anim_tick),
    .o_tc   (w_anim_tc)
  );

  assign w_x_dec = r_x - OUT_WIDTH'(1);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_x       = r_x;
    w_nxt_y       = r_y;
    w_nxt_killed  = 1'b0;
    w_nxt_reached = 1'b0;
    w_step_clr    = 1'b0;
    w_step_tick   = 1'b0;
    w_anim_clr    = 1'b0;
    w_anim_tick   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (spawn_req) begin
          w_nxt_state = ST_FLYING;
          w_nxt_y     = spawn_y;
          w_step_clr  = 1'b1;
        end
      end
      ST_FLYING: begin
        // A hit suppresses any step on the same cycle, so xenemy never lands on X_BASE here.
        if (hit) begin
          w_nxt_state  = ST_EXPLODING;
          w_nxt_killed = 1'b1;
          w_anim_clr   = 1'b1;
        end else if (frame_tick) begin
          w_step_tick = 1'b1;
          if (w_step_tc) begin
            w_nxt_x = w_x_dec;
            if (w_x_dec == LP_X_BASE) begin
              w_nxt_state   = ST_ARRIVED;
              w_nxt_reached = 1'b1;
            end
          end
        end
      end
      ST_EXPLODING: begin
        if (frame_tick) begin
          w_anim_tick = 1'b1;
          if (w_anim_tc) begin
            w_nxt_state = ST_IDLE;
            w_nxt_x     = LP_X_SPAWN;
          end
        end
      end
      ST_ARRIVED: begin
        w_nxt_state = ST_ARRIVED;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_x         <= LP_X_SPAWN;
      r_y         <= '0;
      r_active    <= 1'b0;
      r_exploding <= 1'b0;
      r_killed    <= 1'b0;
      r_reached   <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_x         <= w_nxt_x;
      r_y         <= w_nxt_y;
      r_active    <= (w_nxt_state == ST_FLYING);
      r_exploding <= (w_nxt_state == ST_EXPLODING);
      r_killed    <= w_nxt_killed;
      r_reached   <= w_nxt_reached;
    end
  end

  assign xenemy          = r_x;
  assign yenemy          = r_y;
  assign enemy_active    = r_active;
  assign enemy_exploding = r_exploding;
  assign enemy_killed    = r_killed;
  assign reached_base    = r_reached;

endmodule

// File: tb/tb_enemy_control.sv
// Directed bench for enemy_control with X_SPAWN=10, X_BASE=2, STEP_DIV=2, 3-tick explosion.
module tb_enemy_control;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       spawn_req = 1'b0;
  logic [7:0] spawn_y = 8'd0;
  logic       hit = 1'b0;
  logic [7:0] xenemy, yenemy;
  logic       enemy_active, enemy_exploding, enemy_killed, reached_base;

  int n_cmp = 0;
  int n_err = 0;
  int n_reached = 0;

  enemy_control #(
    .OUT_WIDTH(8), .X_SPAWN(10), .X_BASE(2), .STEP_DIV(2), .DESTROY_ANIMATION_TIME(3)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .spawn_req(spawn_req),
    .spawn_y(spawn_y), .hit(hit), .xenemy(xenemy), .yenemy(yenemy),
    .enemy_active(enemy_active), .enemy_exploding(enemy_exploding),
    .enemy_killed(enemy_killed), .reached_base(reached_base)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs held across the edge; outputs sampled 1 after it.
  task automatic cyc(input logic ft, input logic sr, input logic [7:0] sy, input logic h);
    frame_tick = ft; spawn_req = sr; spawn_y = sy; hit = h;
    @(posedge clk);
    #1;
    frame_tick = 1'b0; spawn_req = 1'b0; hit = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    // 1: async reset without clock
    #1 rst = 1'b1;
    #2;
    chk("rst_x", int'(xenemy), 10);
    chk("rst_y", int'(yenemy), 0);
    chk("rst_flags", int'({enemy_active, enemy_exploding, enemy_killed, reached_base}), 0);
    #2 rst = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 8'd0, 1'b0);
    chk("idle_ticks_x", int'(xenemy), 10);
    chk("idle_ticks_active", int'(enemy_active), 0);

    // 2: full flight to base
    cyc(1'b0, 1'b1, 8'd40, 1'b1);
    chk("spawn_active", int'(enemy_active), 1);
    chk("spawn_x", int'(xenemy), 10);
    chk("spawn_y", int'(yenemy), 40);
    chk("spawn_no_kill", int'(enemy_killed), 0);
    n_reached = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 1'b0, 8'd0, 1'b0);
      chk($sformatf("fly_x_t%0d", k), int'(xenemy), 10 - k / 2);
      if (reached_base) n_reached++;
    end
    chk("arrive_pulse_now", int'(reached_base), 1);
    chk("arrive_pulse_count", n_reached, 1);
    chk("arrive_inactive", int'(enemy_active), 0);
    chk("fly_y", int'(yenemy), 40);
    cyc(1'b1, 1'b0, 8'd0, 1'b0);
    chk("arrive_pulse_gone", int'(reached_base), 0);
    cyc(1'b1, 1'b1, 8'd90, 1'b1);
    chk("arrived_hold_x", int'(xenemy), 2);
    chk("arrived_no_kill", int'(enemy_killed), 0);
    chk("arrived_no_respawn", int'(enemy_active), 0);
    do_reset();

    // 3 + 5: shot down, spawn ignored while busy
    cyc(1'b0, 1'b1, 8'd40, 1'b0);
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 8'd0, 1'b0);
    chk("pre_hit_x", int'(xenemy), 6);
    cyc(1'b0, 1'b1, 8'd77, 1'b0);
    chk("fly_respawn_y", int'(yenemy), 40);
    chk("fly_respawn_x", int'(xenemy), 6);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    chk("hit_killed", int'(enemy_killed), 1);
    chk("hit_exploding", int'(enemy_exploding), 1);
    chk("hit_active", int'(enemy_active), 0);
    chk("hit_x", int'(xenemy), 6);
    cyc(1'b0, 1'b1, 8'd99, 1'b1);
    chk("killed_one_cycle", int'(enemy_killed), 0);
    chk("expl_respawn_y", int'(yenemy), 40);
    chk("expl_still", int'(enemy_exploding), 1);
    cyc(1'b1, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 8'd0, 1'b0);
    chk("expl_t2_x", int'(xenemy), 6);
    chk("expl_t2_flag", int'(enemy_exploding), 1);
    cyc(1'b1, 1'b0, 8'd0, 1'b0);
    chk("expl_done_flag", int'(enemy_exploding), 0);
    chk("expl_done_x", int'(xenemy), 10);
    chk("expl_done_active", int'(enemy_active), 0);

    // 5: respawn gives a fresh full flight
    cyc(1'b0, 1'b1, 8'd50, 1'b0);
    chk("respawn_y", int'(yenemy), 50);
    n_reached = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 1'b0, 8'd0, 1'b0);
      if (reached_base) n_reached++;
      if (k == 15) chk("respawn_x_t15", int'(xenemy), 3);
    end
    chk("respawn_x_end", int'(xenemy), 2);
    chk("respawn_reached", n_reached, 1);
    do_reset();

    // 4: hit coinciding with the final step
    cyc(1'b0, 1'b1, 8'd20, 1'b0);
    for (int k = 0; k < 15; k++) cyc(1'b1, 1'b0, 8'd0, 1'b0);
    chk("race_pre_x", int'(xenemy), 3);
    n_reached = 0;
    cyc(1'b1, 1'b0, 8'd0, 1'b1);
    chk("race_x", int'(xenemy), 3);
    chk("race_exploding", int'(enemy_exploding), 1);
    chk("race_killed", int'(enemy_killed), 1);
    if (reached_base) n_reached++;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 8'd0, 1'b0);
      if (reached_base) n_reached++;
    end
    chk("race_no_reach", n_reached, 0);
    chk("race_back_idle_x", int'(xenemy), 10);

    // 6: async reset mid-flight
    cyc(1'b0, 1'b1, 8'd30, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 8'd0, 1'b0);
    chk("mid_x", int'(xenemy), 5);
    #1 rst = 1'b1;
    #1;
    chk("async_x", int'(xenemy), 10);
    chk("async_active", int'(enemy_active), 0);
    chk("async_y", int'(yenemy), 0);
    #1 rst = 1'b0;
    cyc(1'b0, 1'b1, 8'd60, 1'b0);
    cyc(1'b1, 1'b0, 8'd0, 1'b0);
    chk("post_rst_first_tick", int'(xenemy), 10);
    cyc(1'b1, 1'b0, 8'd0, 1'b0);
    chk("post_rst_second_tick", int'(xenemy), 9);
    chk("post_rst_y", int'(yenemy), 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
